// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller_pkg
// Description : Shared definitions for the MEM-stage SRAM controller: FSM
//               state encoding, off-chip SRAM bus widths and the default
//               byte address at which the SRAM window starts.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_controller_pkg;

  // Off-chip SRAM bus geometry (half-word addressed, 16-bit data)
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  // Byte address that maps to SRAM word 0
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Access FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOW  = 2'd1;
  localparam state_t ST_HIGH = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage : sram_controller_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Runs a 32-bit load/store from the MEM stage as two 16-bit
//               SRAM transactions (low half, then high half), each lasting
//               WAIT_CYCLES clocks. ready_o is low while the access is in
//               flight so the pipeline freezes until it completes.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mem_r_en_i/w_en_i   - load / store request
//               address_i           - byte address from the ALU
//               write_data_i        - store data
//               read_data_o         - loaded word (registered)
//               ready_o             - access complete / no access pending
//               sram_addr_o         - SRAM half-word address
//               sram_dq_out_o/oe_o  - SRAM write data and bus drive enable
//               sram_dq_in_i        - SRAM read data
//               sram_we_n_o         - SRAM write strobe, active low
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en_i,
  input  logic               mem_w_en_i,
  input  logic [31:0]        address_i,
  input  logic [31:0]        write_data_i,
  output logic [31:0]        read_data_o,
  output logic               ready_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [SRAM_DW-1:0] sram_dq_out_o,
  output logic               sram_dq_oe_o,
  input  logic [SRAM_DW-1:0] sram_dq_in_i,
  output logic               sram_we_n_o
);

  localparam logic [3:0] C_LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q;
  logic [16:0]   waddr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   read_data_q;

  logic          w_req;
  logic          w_last;
  logic [31:0]   w_offset;
  logic          w_unused_offset;

  assign w_req  = mem_r_en_i | mem_w_en_i;
  assign w_last = (cnt_q == C_LAST_CNT);

  // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap around.
  assign w_offset = address_i - BASE_ADDR;
  // Byte lane bits and the word-address bits beyond the SRAM are dropped.
  assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic (wait counter advances with the FSM)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (w_req) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      waddr_q     <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
    end else begin
      // Only IDLE accepts a command; inputs are ignored until DONE has passed.
      if (state_q == ST_IDLE && w_req) begin
        wr_q    <= mem_w_en_i;  // both enables high resolves to a write
        waddr_q <= w_offset[18:2];
        wdata_q <= write_data_i;
      end
      // Sample the SRAM on the final wait cycle of each read phase.
      if (!wr_q && w_last) begin
        if (state_q == ST_LOW)  read_data_q[15:0]  <= sram_dq_in_i;
        if (state_q == ST_HIGH) read_data_q[31:16] <= sram_dq_in_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: SRAM bus is a pure function of the registered state, so it
  // is stable for the whole phase and idles cleanly right after reset.
  // --------------------------------------------------------------------------
  always_comb begin
    sram_addr_o   = '0;
    sram_dq_out_o = '0;
    sram_dq_oe_o  = 1'b0;
    sram_we_n_o   = 1'b1;
    ready_o       = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = ~w_req;
      ST_LOW: begin
        sram_addr_o = {waddr_q, 1'b0};
        if (wr_q) begin
          sram_dq_out_o = wdata_q[15:0];
          sram_dq_oe_o  = 1'b1;
          sram_we_n_o   = 1'b0;
        end
      end
      ST_HIGH: begin
        sram_addr_o = {waddr_q, 1'b1};
        if (wr_q) begin
          sram_dq_out_o = wdata_q[31:16];
          sram_dq_oe_o  = 1'b1;
          sram_we_n_o   = 1'b0;
        end
      end
      ST_DONE: ready_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  assign read_data_o = read_data_q;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. A W=2 instance talks
//               to a behavioural SRAM array; a W=1 instance reads from a
//               fixed address-derived pattern for the back-to-back case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  localparam int W0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (WAIT_CYCLES = 2) ----------------
  logic        re0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rd0;
  logic        rdy0, oe0, we_n0;
  logic [17:0] sa0;
  logic [15:0] dqo0, dqi0;

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut0 (
    .clk(clk), .rst(rst),
    .mem_r_en_i(re0), .mem_w_en_i(we0),
    .address_i(addr0), .write_data_i(wdata0),
    .read_data_o(rd0), .ready_o(rdy0),
    .sram_addr_o(sa0), .sram_dq_out_o(dqo0), .sram_dq_oe_o(oe0),
    .sram_dq_in_i(dqi0), .sram_we_n_o(we_n0)
  );

  // SRAM model: unwritten locations read as addr ^ 0xA5A5
  logic [15:0] mem     [0:262143];
  bit          written [0:262143];
  always @(posedge clk) begin
    if (!we_n0 && oe0) begin
      mem[sa0]     <= dqo0;
      written[sa0] <= 1'b1;
    end
  end
  assign dqi0 = written[sa0] ? mem[sa0] : (sa0[15:0] ^ 16'hA5A5);

  // ---------------- DUT 1 (WAIT_CYCLES = 1) ----------------
  logic        re1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] rd1;
  logic        rdy1, oe1, we_n1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_r_en_i(re1), .mem_w_en_i(1'b0),
    .address_i(addr1), .write_data_i(32'd0),
    .read_data_o(rd1), .ready_o(rdy1),
    .sram_addr_o(sa1), .sram_dq_out_o(dqo1), .sram_dq_oe_o(oe1),
    .sram_dq_in_i(dqi1), .sram_we_n_o(we_n1)
  );
  assign dqi1 = sa1[15:0] ^ 16'h5A5A;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One W=2 access; drop > 0 removes the request after that cycle's edge.
  task automatic run_access(input string nm, input logic re, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [17:0] lo, input logic [31:0] exp_rd,
                            input int drop);
    logic [15:0] half;
    @(posedge clk); #1;
    re0 = re; we0 = we; addr0 = a; wdata0 = wd;
    @(negedge clk);
    chk($sformatf("%s c0 ready", nm), 32'(rdy0), 32'd0);
    for (int c = 1; c <= 2*W0+1; c++) begin
      @(posedge clk); #1;
      if (c == drop) begin re0 = 1'b0; we0 = 1'b0; end
      @(negedge clk);
      if (c <= 2*W0) begin
        chk($sformatf("%s c%0d ready", nm, c), 32'(rdy0), 32'd0);
        chk($sformatf("%s c%0d addr", nm, c), 32'(sa0),
            32'(lo) + ((c > W0) ? 32'd1 : 32'd0));
        chk($sformatf("%s c%0d we_n", nm, c), 32'(we_n0), 32'(!we));
        chk($sformatf("%s c%0d oe", nm, c), 32'(oe0), 32'(we));
        if (we) begin
          half = (c > W0) ? wd[31:16] : wd[15:0];
          chk($sformatf("%s c%0d dq", nm, c), 32'(dqo0), 32'(half));
        end
      end else begin
        chk($sformatf("%s done ready", nm), 32'(rdy0), 32'd1);
        chk($sformatf("%s done we_n", nm), 32'(we_n0), 32'd1);
        chk($sformatf("%s done read_data", nm), rd0, exp_rd);
      end
    end
    @(posedge clk); #1;
    re0 = 1'b0; we0 = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [17:0] lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit [7:0] exp_rdy;

    // name,     re, we, address, wdata,        low sram addr, read_data at DONE
    tbl[0] = '{"st1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'h00004, 32'h00000000};
    tbl[1] = '{"ld1032", 1'b1, 1'b0, 32'd1032, 32'h0,        18'h00004, 32'hDEADBEEF};
    tbl[2] = '{"st1020", 1'b0, 1'b1, 32'd1020, 32'h12345678, 18'h3FFFE, 32'hDEADBEEF};
    tbl[3] = '{"ld1020", 1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE, 32'h12345678};
    tbl[4] = '{"ld1027", 1'b1, 1'b0, 32'd1027, 32'h0,        18'h00000, 32'hA5A4A5A5};
    tbl[5] = '{"st1424", 1'b0, 1'b1, 32'd1424, 32'hCAFEF00D, 18'h000C8, 32'hA5A4A5A5};
    tbl[6] = '{"both1036", 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 18'h00006, 32'hA5A4A5A5};
    tbl[7] = '{"ld1036", 1'b1, 1'b0, 32'd1036, 32'h0,        18'h00006, 32'h0BADF00D};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst ready",     32'(rdy0),  32'd1);
    chk("rst we_n",      32'(we_n0), 32'd1);
    chk("rst oe",        32'(oe0),   32'd0);
    chk("rst addr",      32'(sa0),   32'd0);
    chk("rst dq_out",    32'(dqo0),  32'd0);
    chk("rst read_data", rd0,        32'd0);
    chk("rst w1 ready",  32'(rdy1),  32'd1);

    // ---- table of W=2 accesses ----
    for (int i = 0; i < 8; i++)
      run_access(tbl[i].nm, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].wd,
                 tbl[i].lo, tbl[i].exp_rd, 0);

    // ---- reset during the HIGH phase of a write ----
    @(posedge clk); #1;
    we0 = 1'b1; addr0 = 32'd1040; wdata0 = 32'h11112222;
    repeat (W0 + 1) @(posedge clk);
    #1 we0 = 1'b0;
    @(negedge clk);
    chk("midhigh addr", 32'(sa0),   32'd9);
    chk("midhigh we_n", 32'(we_n0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst we_n",      32'(we_n0), 32'd1);
    chk("postrst oe",        32'(oe0),   32'd0);
    chk("postrst ready",     32'(rdy0),  32'd1);
    chk("postrst addr",      32'(sa0),   32'd0);
    chk("postrst read_data", rd0,        32'd0);
    run_access("ld_after_rst", 1'b1, 1'b0, 32'd1032, 32'h0, 18'h00004, 32'hDEADBEEF, 0);

    // ---- request dropped in cycle 2 ----
    run_access("ld_drop", 1'b1, 1'b0, 32'd1424, 32'h0, 18'h000C8, 32'hCAFEF00D, 2);
    @(negedge clk);
    chk("drop idle ready", 32'(rdy0), 32'd1);

    // ---- back-to-back loads, W=1 ----
    exp_rdy = 8'b1000_1000;  // bit c = ready in cycle c
    @(posedge clk); #1;
    re1 = 1'b1; addr1 = 32'd1036;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 4) addr1 = 32'd1064;
      end
      @(negedge clk);
      chk($sformatf("b2b c%0d ready", c), 32'(rdy1), 32'(exp_rdy[c]));
      if (c == 1) chk("b2b c1 addr", 32'(sa1), 32'd6);
      if (c == 5) chk("b2b c5 addr", 32'(sa1), 32'd20);
      if (c == 3) chk("b2b ld1 read_data", rd1, 32'h5A5D5A5C);
      if (c == 7) chk("b2b ld2 read_data", rd1, 32'h5A4F5A4E);
    end
    @(posedge clk); #1 re1 = 1'b0;
    @(negedge clk);
    chk("b2b idle ready", 32'(rdy1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_sram_controller
`default_nettype wire
